// File: rtl/cmd_credit_arbiter_pkg.sv
// Shared constants and types for the PSL command credit arbiter.
// The optional starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
package cmd_credit_arbiter_pkg;

    localparam int NUM_REQ = 6;

    localparam int PRIORITY_RESTART        = 0;
    localparam int PRIORITY_WED            = 1;
    localparam int PRIORITY_WRITE          = 2;
    localparam int PRIORITY_READ           = 3;
    localparam int PRIORITY_PREFETCH_WRITE = 4;
    localparam int PRIORITY_PREFETCH_READ  = 5;

    localparam int CREDITS_READ  = 32;
    localparam int CREDITS_WRITE = 32;
    localparam int CREDITS_TOTAL = CREDITS_READ + CREDITS_WRITE;

    localparam int STARVE_LIMIT = 63;
    localparam int WAIT_W       = 6;

    localparam int SEL_W       = $clog2(NUM_REQ);
    localparam int READ_CNT_W  = $clog2(CREDITS_READ) + 1;
    localparam int WRITE_CNT_W = $clog2(CREDITS_WRITE) + 1;
    localparam int CNT_W       = (READ_CNT_W > WRITE_CNT_W) ? READ_CNT_W : WRITE_CNT_W;

    typedef logic [SEL_W-1:0] arb_sel_t;
    typedef logic [CNT_W-1:0] credit_cnt_t;
    typedef logic [WAIT_W-1:0] wait_cnt_t;

endpackage

// File: rtl/cmd_credit_arbiter_credit_counter.sv
// Per-class credit pool: issue takes a credit, a response returns one.
// A return into a full pool is dropped and latches a sticky error.
module cmd_credit_arbiter_credit_counter #(
    parameter int MAX_CREDITS = 32,
    parameter int CNT_W       = $clog2(MAX_CREDITS) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue,
    input  logic             ret,
    output logic [CNT_W-1:0] count,
    output logic             error
);

    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_CREDITS);

    logic [CNT_W-1:0] count_d, count_q;
    logic             error_d, error_q;

    // Issue at zero cannot happen: the arbiter only grants with credit available.
    always_comb begin
        count_d = count_q;
        error_d = error_q;
        unique case ({issue, ret})
            2'b10: count_d = count_q - CNT_W'(1);
            2'b01: begin
                if (count_q == MAX_VAL) begin
                    error_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= MAX_VAL;
            error_q <= 1'b0;
        end else begin
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    assign count = count_q;
    assign error = error_q;

endmodule

// File: rtl/cmd_credit_arbiter.sv
// Fixed-priority, credit-gated arbiter in front of the PSL command port.
// Define ARB_STARVE_GUARD_EN to add per-requester starvation counters.
module cmd_credit_arbiter
    import cmd_credit_arbiter_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   arb_enable,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_is_write,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   cmd_valid,
    output arb_sel_t               cmd_sel,
    output logic                   cmd_is_write,
    input  logic                   rsp_valid,
    input  logic                   rsp_is_write,
    output logic [READ_CNT_W-1:0]  read_credits,
    output logic [WRITE_CNT_W-1:0] write_credits,
    output logic                   credit_error
);

    logic [NUM_REQ-1:0] eligible;
    logic               grant_any;
    arb_sel_t           grant_sel;
    logic               grant_is_write;
    logic               issue_read, issue_write;
    logic               ret_read, ret_write;
    logic               read_error, write_error;

    logic     cmd_valid_d, cmd_valid_q;
    arb_sel_t cmd_sel_d, cmd_sel_q;
    logic     cmd_is_write_d, cmd_is_write_q;

`ifdef ARB_STARVE_GUARD_EN
    wait_cnt_t wait_d [NUM_REQ];
    wait_cnt_t wait_q [NUM_REQ];
    logic      force_any;
    arb_sel_t  force_sel;
`endif

    // Eligibility only looks at registered credits, so responses never reach req_ready.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] & arb_enable &
                          (req_is_write[i] ? (write_credits != '0) : (read_credits != '0));
        end
    end

    always_comb begin
        grant_any = 1'b0;
        grant_sel = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant_any = 1'b1;
                grant_sel = arb_sel_t'(i);
            end
        end
`ifdef ARB_STARVE_GUARD_EN
        force_any = 1'b0;
        force_sel = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i] && (wait_q[i] >= WAIT_W'(STARVE_LIMIT))) begin
                force_any = 1'b1;
                force_sel = arb_sel_t'(i);
            end
        end
        if (force_any) begin
            grant_sel = force_sel;
        end
`endif
        req_ready      = grant_any ? (NUM_REQ'(1) << grant_sel) : '0;
        grant_is_write = req_is_write[grant_sel];
    end

    assign issue_read  = grant_any & ~grant_is_write;
    assign issue_write = grant_any & grant_is_write;
    assign ret_read    = rsp_valid & ~rsp_is_write;
    assign ret_write   = rsp_valid & rsp_is_write;

    cmd_credit_arbiter_credit_counter #(
        .MAX_CREDITS (CREDITS_READ),
        .CNT_W       (READ_CNT_W)
    ) u_read_pool (
        .clock (clock),
        .reset (reset),
        .issue (issue_read),
        .ret   (ret_read),
        .count (read_credits),
        .error (read_error)
    );

    cmd_credit_arbiter_credit_counter #(
        .MAX_CREDITS (CREDITS_WRITE),
        .CNT_W       (WRITE_CNT_W)
    ) u_write_pool (
        .clock (clock),
        .reset (reset),
        .issue (issue_write),
        .ret   (ret_write),
        .count (write_credits),
        .error (write_error)
    );

    assign credit_error = read_error | write_error;

    always_comb begin
        cmd_valid_d    = grant_any;
        cmd_sel_d      = grant_sel;
        cmd_is_write_d = grant_any & grant_is_write;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_valid_q    <= 1'b0;
            cmd_sel_q      <= '0;
            cmd_is_write_q <= 1'b0;
        end else begin
            cmd_valid_q    <= cmd_valid_d;
            cmd_sel_q      <= cmd_sel_d;
            cmd_is_write_q <= cmd_is_write_d;
        end
    end

    assign cmd_valid    = cmd_valid_q;
    assign cmd_sel      = cmd_sel_q;
    assign cmd_is_write = cmd_is_write_q;

`ifdef ARB_STARVE_GUARD_EN
    // Counters saturate at the limit and clear on grant or loss of eligibility.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            wait_d[i] = '0;
            if (eligible[i] && !req_ready[i]) begin
                wait_d[i] = (wait_q[i] < WAIT_W'(STARVE_LIMIT)) ? (wait_q[i] + WAIT_W'(1)) : wait_q[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset) begin
                wait_q[i] <= '0;
            end else begin
                wait_q[i] <= wait_d[i];
            end
        end
    end
`endif

endmodule
